// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants: operand widths, controller state encoding and
// the add/subtract op encoding used by the modular add/sub controller.
package rsa_pkg;

  localparam int N  = 1024;
  localparam int AW = 1027;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_WAIT1  = 3'd3,
    ST_SETUP2 = 3'd4,
    ST_ISSUE2 = 3'd5,
    ST_WAIT2  = 3'd6,
    ST_FIN    = 3'd7
  } state_t;

endpackage

// File: rtl/mod_corr_sel.sv
// Final-result select for the modular add/sub controller: an add keeps S when
// S - M went negative; every other completion takes the latest adder result.
module mod_corr_sel #(
  parameter int W = 1024
) (
  input  logic         op,
  input  logic         borrow,
  input  logic [W-1:0] s_val,
  input  logic [W-1:0] t_val,
  output logic [W-1:0] sel
);
  import rsa_pkg::*;

  // pick between the uncorrected sum and the adder output
  always_comb begin
    sel = t_val;
    if ((op == OP_ADD) && borrow) begin
      sel = s_val;
    end else begin
      sel = t_val;
    end
  end

endmodule

// File: rtl/mod_addsub_ctrl.sv
// Sequences (A + B) mod M or (A - B) mod M as one or two jobs on the shared
// multi-cycle mpadder, with a conditional correction pass.
module mod_addsub_ctrl #(
  parameter int N  = rsa_pkg::N,
  parameter int AW = rsa_pkg::AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          op_sub,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          add_start,
  output logic          add_subtract,
  output logic [AW-1:0] add_in_a,
  output logic [AW-1:0] add_in_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);
  import rsa_pkg::*;

  state_t        state_r;
  logic          op_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  m_r;
  logic [AW:0]   p1_r;
  logic [N-1:0]  result_r;
  logic          done_r;
  logic          busy_r;
  logic          add_start_r;
  logic          add_sub_r;
  logic [AW-1:0] add_in_a_r;
  logic [AW-1:0] add_in_b_r;

  logic [N-1:0]  sel_s;
  logic          need_p2_s;
  logic          unused_s;

  // An add always needs the S - M trial; a subtract only when A - B borrowed.
  assign need_p2_s = (op_r == OP_ADD) || add_result[AW];
  // Pass-1 sign is consumed straight off the adder bus, not from the capture.
  assign unused_s  = p1_r[AW];

  mod_corr_sel #(.W(N)) u_corr_sel (
    .op     (op_r),
    .borrow (add_result[AW]),
    .s_val  (p1_r[N-1:0]),
    .t_val  (add_result[N-1:0]),
    .sel    (sel_s)
  );

  // controller FSM with registered adder interface and job outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      op_r        <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      m_r         <= '0;
      p1_r        <= '0;
      result_r    <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      add_start_r <= 1'b0;
      add_sub_r   <= 1'b0;
      add_in_a_r  <= '0;
      add_in_b_r  <= '0;
    end else begin
      add_start_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= in_a;
            b_r     <= in_b;
            m_r     <= in_m;
            op_r    <= op_sub;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          add_in_a_r  <= {{(AW-N){1'b0}}, a_r};
          add_in_b_r  <= {{(AW-N){1'b0}}, b_r};
          add_sub_r   <= op_r;
          add_start_r <= 1'b1;
          state_r     <= ST_ISSUE1;
        end
        ST_ISSUE1: begin
          state_r <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (add_done) begin
            p1_r <= add_result;
            if (need_p2_s) begin
              state_r <= ST_SETUP2;
            end else begin
              result_r <= sel_s;
              done_r   <= 1'b1;
              state_r  <= ST_FIN;
            end
          end
        end
        ST_SETUP2: begin
          // add: S - M trial; subtract: D + M correction
          add_in_a_r  <= p1_r[AW-1:0];
          add_in_b_r  <= {{(AW-N){1'b0}}, m_r};
          add_sub_r   <= ~op_r;
          add_start_r <= 1'b1;
          state_r     <= ST_ISSUE2;
        end
        ST_ISSUE2: begin
          state_r <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (add_done) begin
            result_r <= sel_s;
            done_r   <= 1'b1;
            state_r  <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign result       = result_r;
  assign done         = done_r;
  assign busy         = busy_r;
  assign add_start    = add_start_r;
  assign add_subtract = add_sub_r;
  assign add_in_a     = add_in_a_r;
  assign add_in_b     = add_in_b_r;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench for mod_addsub_ctrl with a behavioral fixed-latency adder
// and a result scoreboard fed from an independent modular reference.
module tb_mod_addsub_ctrl;
  import rsa_pkg::*;

  localparam int L = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start;
  logic          op_sub;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [N-1:0]  in_m;
  logic [N-1:0]  result;
  logic          done;
  logic          busy;
  logic          add_start;
  logic          add_subtract;
  logic [AW-1:0] add_in_a;
  logic [AW-1:0] add_in_b;
  logic [AW:0]   add_result;
  logic          add_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [N-1:0] sb_q[$];

  mod_addsub_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .op_sub       (op_sub),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioral mpadder: add_done arrives L cycles after the add_start cycle
  int lat_cnt = 0;
  always @(posedge clk) begin
    if (!resetn) begin
      lat_cnt    <= 0;
      add_done   <= 1'b0;
      add_result <= '0;
    end else begin
      add_done <= (lat_cnt == 1);
      if (add_start) begin
        lat_cnt    <= L - 1;
        add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                   : ({1'b0, add_in_a} + {1'b0, add_in_b});
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [AW:0] got, input logic [AW:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got[127:0], want[127:0]);
    end
  endtask

  // adder operands must hold from add_start through add_done
  logic          pend = 1'b0;
  logic [AW-1:0] sv_a;
  logic [AW-1:0] sv_b;
  logic          sv_s;
  always @(negedge clk) begin
    if (!resetn) begin
      pend <= 1'b0;
    end else if (add_start) begin
      chk("start_with_done", add_done, 1'b0);
      pend <= 1'b1;
      sv_a <= add_in_a;
      sv_b <= add_in_b;
      sv_s <= add_subtract;
    end else if (pend) begin
      chk("stable_a", add_in_a, sv_a);
      chk("stable_b", add_in_b, sv_b);
      chk("stable_sub", add_subtract, sv_s);
      if (add_done) pend <= 1'b0;
    end
  end

  function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, b, m, input logic op);
    logic [N:0] s;
    if (op == OP_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a - b};
    end else begin
      s = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_reset(input string ctx);
    chk({ctx, "_result"}, result, '0);
    chk({ctx, "_done"}, done, 1'b0);
    chk({ctx, "_busy"}, busy, 1'b0);
    chk({ctx, "_add_start"}, add_start, 1'b0);
    chk({ctx, "_add_sub"}, add_subtract, 1'b0);
    chk({ctx, "_add_in_a"}, add_in_a, '0);
    chk({ctx, "_add_in_b"}, add_in_b, '0);
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after done
  task automatic run_job(input logic [N-1:0] a, b, m, input logic op, input int glitch_at);
    logic [N-1:0] want;
    logic         two;
    int           t0, ns, nb, k;
    want = ref_mod(a, b, m, op);
    two  = (op == OP_ADD) || (a < b);
    chk("idle_before_start", busy, 1'b0);
    in_a = a; in_b = b; in_m = m; op_sub = op; start = 1'b1;
    t0 = cyc;
    sb_q.push_back(want);
    @(negedge clk);
    start = 1'b0; in_a = ~a; in_b = ~b; in_m = ~m; op_sub = ~op;
    ns = 0; nb = 0; k = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy === 1'b1) nb++;
      if (add_start === 1'b1) ns++;
      start = ((cyc - t0) == glitch_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (busy === 1'b1) nb++;
    chk("done_seen", done, 1'b1);
    chk("latency", cyc - t0, two ? 2 * L + 5 : L + 3);
    chk("busy_cycles", nb, two ? 2 * L + 5 : L + 3);
    chk("add_starts", ns, two ? 2 : 1);
    if (sb_q.size() > 0) chk("result", result, sb_q.pop_front());
    else chk("scoreboard_empty", sb_q.size(), 1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b, m;
    int t0;
    start = 1'b0; op_sub = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    resetn = 1'b1;
    @(negedge clk);

    run_job(1024'd5, 1024'd7, 1024'd11, OP_ADD, -1);
    run_job(1024'd3, 1024'd4, 1024'd11, OP_ADD, -1);
    run_job(1024'd6, 1024'd5, 1024'd11, OP_ADD, -1);
    run_job(1024'd3, 1024'd7, 1024'd11, OP_SUB, -1);
    run_job(1024'd7, 1024'd3, 1024'd11, OP_SUB, -1);
    run_job(1024'd9, 1024'd9, 1024'd11, OP_SUB, -1);

    // stray start pulse while waiting on pass 1
    run_job(1024'd2, 1024'd10, 1024'd11, OP_ADD, 4);
    @(negedge clk);
    chk("glitch_not_queued", busy, 1'b0);

    m = {N{1'b1}};
    a = m - 1024'd1;
    run_job(a, a, m, OP_ADD, -1);
    run_job(a, a, m, OP_SUB, -1);

    // reset during the second adder pass
    in_a = 1024'd5; in_b = 1024'd7; in_m = 1024'd11; op_sub = OP_ADD; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((cyc - t0) < 11) @(negedge clk);
    chk("busy_in_wait2", busy, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset("mid_job");
    @(negedge clk);
    chk("no_done_in_reset", done, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    chk("add_start_after_rst", add_start, 1'b0);
    chk("no_done_after_rst", done, 1'b0);
    run_job(1024'd3, 1024'd4, 1024'd11, OP_ADD, -1);

    for (int op = 0; op < 2; op++) begin
      for (int i = 0; i < 1000; i++) begin
        m = rand_n();
        if (m == '0) m = 1024'd1;
        a = rand_n() % m;
        b = rand_n() % m;
        run_job(a, b, m, op[0], -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_addsub_ctrl.md
# mod_addsub_ctrl

Sequencing controller that computes (A + B) mod M or (A − B) mod M for 1024-bit RSA operands by issuing two back-to-back jobs to the team's shared multi-cycle multi-precision adder (mpadder). It is the initiator side of the adder's start/subtract/operand → result/done interface, with a conditional-correction step. It sits between the modular-exponentiation datapath and the adder. It replaces ad-hoc per-caller adder sequencing.

## Interface
Parameters:
- N, 1024, operand/modulus width.
- AW, 1027, adder operand width; operands are zero-extended from N to AW.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- op_sub  in  1  0 = modular add, 1 = modular subtract; sampled with start.
- in_a  in  N  operand A; precondition A < M.
- in_b  in  N  operand B; precondition B < M.
- in_m  in  N  modulus M; M ≠ 0.
- result  out  N  registered modular result, valid when done pulses and held until next done.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- add_start  out  1  one-cycle start pulse to the adder.
- add_subtract  out  1  adder mode.
- add_in_a  out  AW  adder operand a.
- add_in_b  out  AW  adder operand b.
- add_result  in  AW+1  adder result; bit AW is the carry for add and the borrow (1 = negative) for subtract.
- add_done  in  1  adder completion pulse.

## Operation
- On an accepted start, latch A, B, M and op_sub into internal registers. Later changes on the in_* inputs have no effect on the job.
- Add job:
  - Pass 1 computes S = A + B (add_subtract = 0).
  - Pass 2 computes T = S − M (add_subtract = 1).
  - If bit AW of T is 1, result = S[N-1:0]; otherwise result = T[N-1:0].
- Subtract job:
  - Pass 1 computes D = A − B (add_subtract = 1).
  - If bit AW of D is 0, finish with result = D[N-1:0] and skip pass 2.
  - Otherwise pass 2 computes D[AW-1:0] + M (add_subtract = 0), and result = its low N bits.
- The pass-1 result is captured into a register, AW+1 bits wide, on the add_done cycle. That register feeds add_in_a for pass 2.
- add_in_a, add_in_b and add_subtract are driven from registers. They are stable from the add_start cycle through the add_done cycle of the same pass.
- States:
  - IDLE: start → LOAD.
  - LOAD: latch operands and drive pass-1 operands.
  - ISSUE1: add_start = 1 → WAIT1.
  - WAIT1: on add_done → SETUP2 when pass 2 is needed, else → FIN.
  - SETUP2: drive pass-2 operands.
  - ISSUE2: add_start = 1 → WAIT2.
  - WAIT2: on add_done → FIN.
  - FIN: result updated, done = 1 → IDLE.
- start during any state other than IDLE is ignored; it is neither queued nor allowed to corrupt the latched operands.
- An add_done outside WAIT1/WAIT2 is ignored.

## Timing
- Reset values: result = 0, done = 0, busy = 0, add_start = 0, add_subtract = 0, add_in_a = 0, add_in_b = 0; state IDLE.
- Reset mid-job aborts the job. No done is issued. add_start is low in the cycle after reset releases.
- Latency, with L = adder cycles from the add_start cycle to the add_done cycle:
  - Two passes: done occurs 2L + 5 cycles after the start cycle.
  - Subtract with no correction: done occurs L + 3 cycles after the start cycle.
- add_start is never asserted on the same cycle as add_done.
- The minimum gap between a pass's add_done and the next add_start is 2 cycles (SETUP2 + ISSUE2). This guarantees the adder has returned to idle.
- A start accepted on the cycle after done is legal (back-to-back jobs).
- Boundary cases:
  - A + B = M gives T = 0 with no borrow, so result = 0.
  - A = B gives result = 0 with no correction pass.

## Structure
- A shared package, rsa_pkg, holds:
  - the N and AW constants;
  - the state-enumeration localparams;
  - the op encoding (OP_ADD = 0, OP_SUB = 1).
- The block consists of a single FSM plus datapath registers. It does not instantiate the adder; the top level wires it to mpadder.
- One natural sub-module, mod_corr_sel: a combinational select of the final result from the borrow bit and op. Keep it small.

## Test plan
- Add, 5 + 7 mod 11 with a behavioral adder model of L = 5 → result = 1, done at start + 15, busy high for exactly 15 cycles.
- Add without wrap, 3 + 4 mod 11 → result = 7. Also 6 + 5 mod 11 → result = 0 (A + B = M boundary).
- Subtract, 3 − 7 mod 11 → result = 7 via the correction pass. Subtract 7 − 3 mod 11 → result = 4, with exactly one add_start issued and done at start + 8.
- Full width, A = B = M − 1 with M = 2^1024 − 1, add → result = M − 2. Subtract → result = 0. Cross-check both against a reference model over 1000 random (A, B < M) pairs per op.
- Protocol checks:
  - start pulsed in WAIT1 is ignored and the result is unaffected.
  - The in_a/in_b/in_m inputs change after the start cycle and the result is unaffected.
  - An assertion confirms add_in_a, add_in_b and add_subtract are stable from add_start to add_done.
- Reset mid-WAIT2 → outputs return to their reset values. No done. A new job started 1 cycle after reset release completes correctly.
